// File: rtl/lif_stream_loader_if.sv
// lif_stream_loader_if: job request and neuron byte-bus signals of the loader
interface lif_stream_loader_if #(parameter int N_STAGES = 5);
  localparam int INPUTS = 2 ** N_STAGES;
  logic              start;
  logic              load_weights;
  logic [INPUTS-1:0] inputs_vec;
  logic [INPUTS-1:0] weights_vec;
  logic [7:0]        run_cycles;
  logic              spike_in;
  logic [7:0]        data_out;
  logic              weights_sel;
  logic              load_n;
  logic              busy;
  logic              done;
  logic [7:0]        spike_count;
  modport master (
    output start, load_weights, inputs_vec, weights_vec, run_cycles, spike_in,
    input  data_out, weights_sel, load_n, busy, done, spike_count
  );
  modport slave (
    input  start, load_weights, inputs_vec, weights_vec, run_cycles, spike_in,
    output data_out, weights_sel, load_n, busy, done, spike_count
  );
endinterface

// File: rtl/lif_stream_loader.sv
// lif_stream_loader: serialises weight/input vectors to the LIF neuron, runs it and counts spikes
module lif_stream_loader #(parameter int N_STAGES = 5) (
  input logic clk,
  input logic reset,
  lif_stream_loader_if.slave bus
);
  localparam int INPUTS = 2 ** N_STAGES;
  localparam int NB = INPUTS / 8 > 1 ? INPUTS / 8 : 1;
  localparam int CW = NB > 1 ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, RUN, DONE} state_t;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [7:0]        rc;
  logic [INPUTS-1:0] xv, wv;
  function automatic logic [7:0] byte_of(input logic [INPUTS-1:0] v, input logic [CW-1:0] j);
    logic [8*NB-1:0] p;
    p = '0;
    p[INPUTS-1:0] = v;
    return p[8*(NB-1-int'(j)) +: 8];
  endfunction
  // job sequencer; every output is set one edge ahead so it is registered in its own cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      rc              <= '0;
      xv              <= '0;
      wv              <= '0;
      bus.data_out    <= '0;
      bus.weights_sel <= 1'b0;
      bus.load_n      <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.spike_count <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          xv              <= bus.inputs_vec;
          wv              <= bus.weights_vec;
          rc              <= bus.run_cycles;
          cnt             <= '0;
          bus.spike_count <= '0;
          bus.busy        <= 1'b1;
          state           <= bus.load_weights ? LOAD_W : LOAD_X;
          bus.weights_sel <= bus.load_weights;
          bus.data_out    <= byte_of(bus.load_weights ? bus.weights_vec : bus.inputs_vec, '0);
        end
        LOAD_W: begin
          cnt             <= cnt == LAST ? '0 : cnt + 1'b1;
          state           <= cnt == LAST ? LOAD_X : LOAD_W;
          bus.weights_sel <= cnt != LAST;
          bus.data_out    <= cnt == LAST ? byte_of(xv, '0) : byte_of(wv, cnt + 1'b1);
        end
        LOAD_X: begin
          cnt <= cnt == LAST ? '0 : cnt + 1'b1;
          if (cnt == LAST) begin
            state        <= rc != 8'd0 ? RUN : DONE;
            bus.load_n   <= rc != 8'd0;
            bus.done     <= rc == 8'd0;
            bus.data_out <= '0;
          end else begin
            bus.data_out <= byte_of(xv, cnt + 1'b1);
          end
        end
        RUN: begin
          if (bus.spike_in && bus.spike_count != 8'hFF) bus.spike_count <= bus.spike_count + 1'b1;
          rc <= rc - 1'b1;
          if (rc == 8'd1) begin
            state      <= DONE;
            bus.load_n <= 1'b0;
            bus.done   <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/lif_stream_loader.md
Name: lif_stream_loader

Overview:
- Host-side transmitter for the LIF neuron's byte-load interface.
- Takes a full input vector and an optional weight vector, serialises them as bytes onto the neuron's 8-bit data bus with the matching mode pins, then drives N integration cycles.
- Counts the spikes the neuron returns during those cycles.
- Sits beside the neuron in test/demo tops; its outputs map directly onto the neuron's data, weight-select and mode pins.

Parameters:
- N_STAGES, 5: neuron adder-tree depth; INPUTS = WEIGHTS = 2**N_STAGES.
- NB, derived: bytes per vector = max(1, INPUTS/8).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- load_weights  in  1  1 = send weight vector before inputs in this job.
- inputs_vec  in  INPUTS  input spike vector for the job.
- weights_vec  in  INPUTS  weight-sign vector for the job.
- run_cycles  in  8  number of integration cycles (0..255).
- spike_in  in  1  neuron spike output.
- data_out  out  8  byte bus to the neuron's data pins.
- weights_sel  out  1  to neuron weight-select pin: 1 = weights, 0 = inputs.
- load_n  out  1  to neuron mode pin: 0 = byte-load mode, 1 = integrate.
- busy  out  1  high while a job is in progress.
- done  out  1  one-cycle pulse at job completion.
- spike_count  out  8  spikes counted in the last job; saturating.

Behaviour:
- Reset (async, active-high): state=IDLE; data_out=0, weights_sel=0, load_n=0, busy=0, done=0, spike_count=0; latched job registers cleared.
- Reset mid-job aborts immediately. No partial byte stream resumes after reset deasserts.
- FSM states: IDLE, LOAD_W, LOAD_X, RUN, DONE.
- IDLE outputs: load_n=0, weights_sel=0, data_out=0.
  - The neuron input register shifts in zeros.
  - Weights and membrane are preserved.
- IDLE, start=1 at edge k:
  - Latch inputs_vec, weights_vec, run_cycles, load_weights.
  - Clear spike_count.
  - Go to LOAD_W if load_weights=1, else LOAD_X.
- start while busy is ignored; inputs changing during a job have no effect.
- LOAD_W / LOAD_X:
  - NB cycles each; load_n=0; weights_sel=1 in LOAD_W, 0 in LOAD_X.
  - Byte order is most-significant first: cycle j (0..NB-1) drives vec[8*(NB-1-j) +: 8].
  - If INPUTS<8: data_out = {zeros, vec}.
  - A byte counter drives sequencing; it wraps to 0 on state exit.
- After LOAD_W go to LOAD_X. After LOAD_X:
  - go to RUN if run_cycles>0;
  - go to DONE if run_cycles=0.
- RUN:
  - load_n=1, weights_sel=0, data_out=0 for exactly run_cycles cycles.
  - spike_in sampled every RUN cycle; the same-cycle combinational spike is valid.
  - spike_count increments per high sample and saturates at 255.
- DONE:
  - One cycle; done=1, load_n=0, weights_sel=0, data_out=0.
  - Then IDLE. start in the DONE cycle is ignored.
- busy is high in LOAD_W, LOAD_X, RUN, DONE and low in IDLE.
- Job length from edge k: busy for (load_weights?NB:0) + NB + run_cycles + 1 cycles. done occurs in the last of these.
- spike_count holds its value in IDLE until the next accepted start.
- All outputs are registered (state-decoded from registers); no combinational path from start or spike_in to any output.

Test Plan:
- Reset mid-RUN:
  - Start a job with run_cycles=10; assert reset in RUN cycle 4.
  - All outputs go to 0 immediately. After release, state is IDLE with busy=0.
- Full job, N_STAGES=5, load_weights=1, weights_vec=0xDEADBEEF, inputs_vec=0x12345678, run_cycles=3, spike_in high in RUN cycles 0 and 2:
  - data_out is DE,AD,BE,EF with weights_sel=1, then 12,34,56,78 with weights_sel=0; load_n=0 for those 8 cycles.
  - load_n=1 for 3 cycles.
  - done in cycle 12 after start; spike_count=2.
- Inputs-only job, load_weights=0, inputs_vec=0xFFFFFFFF, run_cycles=0:
  - Exactly 4 byte cycles of FF with weights_sel=0.
  - Never load_n=1; done in cycle 5; spike_count=0.
- Saturation: run_cycles=255 with spike_in held at 1 → spike_count=255.
- Repeat: run_cycles=300 is impossible (8-bit); instead run two back-to-back 255-cycle jobs → each reports 255, and the count clears at each start.
- Ignored start: pulse start during LOAD_X and during DONE.
  - Neither creates a second job; busy drops once.
  - The next start in IDLE is accepted.
- Co-simulation with the neuron, N_STAGES=3 (NB=1), threshold 5, all weights +1, inputs 0xFF:
  - Loader sends a single byte FF.
  - The neuron spikes on RUN cycle 0; spike_count matches the neuron's reference spike train over run_cycles=8.
